// File: rtl/weight_buffer_pkg.sv
// Shared defaults, reader state encoding and the index-to-element mapping
// used by the ping-pong weight buffer.
package weight_buffer_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_N_ROW  = 9;
  localparam int DEF_N_COL  = 9;
  localparam int DEF_IDX_W  = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
  } elem_pos_t;

  // Address width for an n-entry dimension, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Row-major beats fill a row at a time; transposed beats fill a column
  // at a time. An out-of-range index yields row or col beyond the matrix.
  function automatic elem_pos_t map_index(input int idx, input logic transpose,
                                          input int n_row, input int n_col);
    elem_pos_t p;
    if (transpose) begin
      p.row = 16'(idx % n_row);
      p.col = 16'(idx / n_row);
    end else begin
      p.row = 16'(idx / n_col);
      p.col = 16'(idx % n_col);
    end
    return p;
  endfunction

endpackage

// File: rtl/weight_buffer_pp_weight_bank.sv
// One N_ROW x N_COL weight matrix: single write port and a combinational
// column read that places row 0 in the most-significant lane.
module weight_bank
  import weight_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_ROW  = DEF_N_ROW,
  parameter int N_COL  = DEF_N_COL,
  parameter int ROW_AW = addr_w(DEF_N_ROW),
  parameter int COL_AW = addr_w(DEF_N_COL)
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [ROW_AW-1:0]       wr_row_i,
  input  logic [COL_AW-1:0]       wr_col_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic [COL_AW-1:0]       rd_col_i,
  output logic [N_ROW*DATA_W-1:0] col_data_o
);

  // Storage is deliberately not reset; unwritten elements keep old values.
  logic [DATA_W-1:0] mem_q [N_ROW][N_COL];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  for (genvar r = 0; r < N_ROW; r++) begin : g_lane
    assign col_data_o[(N_ROW-1-r)*DATA_W +: DATA_W] = mem_q[r][rd_col_i];
  end

endmodule

// File: rtl/weight_buffer_pp.sv
// Ping-pong weight store: AXI read beats fill one bank while the other,
// already committed bank streams to the systolic array a column at a time.
module weight_buffer_pp
  import weight_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_ROW  = DEF_N_ROW,
  parameter int N_COL  = DEF_N_COL,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESET,
  input  logic                    init_txn_pulse,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [IDX_W-1:0]        wr_index,
  input  logic                    wr_last,
  input  logic                    transpose,
  input  logic                    start,
  output logic                    col_valid,
  input  logic                    col_ready,
  output logic [N_ROW*DATA_W-1:0] col_data,
  output logic [IDX_W-1:0]        col_index,
  output logic                    col_last,
  output logic                    done,
  output logic [1:0]              bank_full,
  output logic                    err_index
);

  localparam int ROW_AW = addr_w(N_ROW);
  localparam int COL_AW = addr_w(N_COL);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(N_COL - 1);

  // Both ports transfer on a cycle where valid && ready are high at the
  // rising edge; a column offer holds its payload until that edge occurs.
  logic                    soft_rst;
  logic                    wbank_q, rbank_q;
  logic [1:0]              full_q, full_d;
  logic                    err_q;
  rd_state_e               state_q;
  logic                    col_valid_q, col_last_q, done_q;
  logic [N_ROW*DATA_W-1:0] col_data_q;
  logic [IDX_W-1:0]        col_idx_q;

  logic                    wr_fire, in_range, take, last_take, launch;
  elem_pos_t               pos;
  logic [IDX_W-1:0]        nxt_idx_d;
  logic [COL_AW-1:0]       rd_col;
  logic [1:0]              we;
  logic [N_ROW*DATA_W-1:0] bank0_col, bank1_col, sel_col;

  assign soft_rst  = M_AXI_ARESET | init_txn_pulse;
  assign wr_ready  = ~full_q[wbank_q];
  assign wr_fire   = wr_valid & wr_ready;
  assign pos       = map_index(int'(wr_index), transpose, N_ROW, N_COL);
  assign in_range  = (pos.row < 16'(N_ROW)) && (pos.col < 16'(N_COL));
  assign we[0]     = wr_fire & in_range & ~wbank_q;
  assign we[1]     = wr_fire & in_range & wbank_q;

  assign take      = col_valid_q & col_ready;
  assign last_take = take & col_last_q;
  assign launch    = (state_q == IDLE) & start & full_q[rbank_q];

  // The column fetched this cycle is the one registered on the next edge.
  assign nxt_idx_d = (state_q == STREAM) ? col_idx_q + IDX_W'(1) : '0;
  assign rd_col    = nxt_idx_d[COL_AW-1:0];
  assign sel_col   = rbank_q ? bank1_col : bank0_col;

  weight_bank #(
    .DATA_W(DATA_W), .N_ROW(N_ROW), .N_COL(N_COL),
    .ROW_AW(ROW_AW), .COL_AW(COL_AW)
  ) u_bank0 (
    .clk_i     (M_AXI_ACLK),
    .we_i      (we[0]),
    .wr_row_i  (pos.row[ROW_AW-1:0]),
    .wr_col_i  (pos.col[COL_AW-1:0]),
    .wr_data_i (wr_data),
    .rd_col_i  (rd_col),
    .col_data_o(bank0_col)
  );

  weight_bank #(
    .DATA_W(DATA_W), .N_ROW(N_ROW), .N_COL(N_COL),
    .ROW_AW(ROW_AW), .COL_AW(COL_AW)
  ) u_bank1 (
    .clk_i     (M_AXI_ACLK),
    .we_i      (we[1]),
    .wr_row_i  (pos.row[ROW_AW-1:0]),
    .wr_col_i  (pos.col[COL_AW-1:0]),
    .wr_data_i (wr_data),
    .rd_col_i  (rd_col),
    .col_data_o(bank1_col)
  );

  // Writer set and reader clear can never hit the same bank in one cycle.
  always_comb begin
    full_d = full_q;
    if (wr_fire && wr_last) full_d[wbank_q] = 1'b1;
    if (last_take)          full_d[rbank_q] = 1'b0;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (soft_rst) begin
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      full_q      <= 2'b00;
      err_q       <= 1'b0;
      state_q     <= IDLE;
      col_valid_q <= 1'b0;
      col_data_q  <= '0;
      col_idx_q   <= '0;
      col_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      full_q <= full_d;
      done_q <= 1'b0;
      if (wr_fire) begin
        if (!in_range) err_q   <= 1'b1;
        if (wr_last)   wbank_q <= ~wbank_q;
      end
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q     <= STREAM;
            col_valid_q <= 1'b1;
            col_data_q  <= sel_col;
            col_idx_q   <= '0;
            col_last_q  <= (N_COL == 1);
          end
        end
        STREAM: begin
          if (take) begin
            if (col_last_q) begin
              state_q     <= IDLE;
              col_valid_q <= 1'b0;
              col_last_q  <= 1'b0;
              done_q      <= 1'b1;
              rbank_q     <= ~rbank_q;
            end else begin
              col_data_q  <= sel_col;
              col_idx_q   <= nxt_idx_d;
              col_last_q  <= (nxt_idx_d == LAST_COL);
            end
          end
        end
      endcase
    end
  end

  assign col_valid = col_valid_q;
  assign col_data  = col_data_q;
  assign col_index = col_idx_q;
  assign col_last  = col_last_q;
  assign done      = done_q;
  assign bank_full = full_q;
  assign err_index = err_q;

endmodule
